// File: rtl/seq_shift_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : shifter_pkg                                                     |
// | Brief    : Shared operation/state encodings for the sequential shifter.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package shifter_pkg;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

  localparam int DEF_WIDTH = 16;

  // A request skips the SHIFT state when there is nothing to step through.
  function automatic logic skip_shift(input shift_op_e op, input logic amt_zero,
                                      input logic ror_en);
    return amt_zero || ((op == OP_ROR) && !ror_en);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_shift_unit_if.sv
// +----------------------------------------------------------------------------+
// | Module   : seq_shift_unit_if                                               |
// | Brief    : Request/result valid-ready bundle for the sequential shifter.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

interface seq_shift_unit_if
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = $clog2(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  shift_op_e        in_op;
  logic [AMT_W-1:0] in_amt;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_cout;

  modport master (
    output in_valid, in_op, in_amt, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_cout
  );

  modport slave (
    input  in_valid, in_op, in_amt, in_data, out_ready,
    output in_ready, out_valid, out_data, out_cout
  );

endinterface

`default_nettype wire

// File: rtl/seq_shift_unit_shift_step.sv
// +----------------------------------------------------------------------------+
// | Module   : shift_step                                                      |
// | Brief    : Combinational single-bit shift/rotate step with carry-out bit.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  shift_op_e        i_op,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_bit
);

  always_comb begin
    o_data = i_data;
    o_bit  = 1'b0;
    case (i_op)
      OP_LSL: begin
        o_data = {i_data[WIDTH-2:0], 1'b0};
        o_bit  = i_data[WIDTH-1];
      end
      OP_LSR: begin
        o_data = {1'b0, i_data[WIDTH-1:1]};
        o_bit  = i_data[0];
      end
      // MSB never changes under ASR, so the current MSB is the original sign bit.
      OP_ASR: begin
        o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
        o_bit  = i_data[0];
      end
      OP_ROR: begin
        o_data = {i_data[0], i_data[WIDTH-1:1]};
        o_bit  = i_data[0];
      end
      default: begin
        o_data = i_data;
        o_bit  = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seq_shift_unit.sv
// +----------------------------------------------------------------------------+
// | Module   : seq_shift_unit                                                  |
// | Brief    : Multi-cycle variable shifter, one bit position per clock.       |
// |            Define SHIFTER_ROR_EN to make op 11 a rotate right; otherwise   |
// |            op 11 passes the operand through unchanged.                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_shift_unit
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_shift_unit_if.slave  bus
);

`ifdef SHIFTER_ROR_EN
  localparam logic c_ror_en = 1'b1;
`else
  localparam logic c_ror_en = 1'b0;
`endif

  localparam logic [AMT_W-1:0] c_amt_one  = AMT_W'(1);
  localparam logic [AMT_W-1:0] c_amt_zero = '0;

  shift_state_e     r_state;
  shift_state_e     w_state_nxt;
  shift_op_e        r_op;
  logic [WIDTH-1:0] r_work;
  logic [AMT_W-1:0] r_count;
  logic             r_cout;

  logic             w_accept;
  logic             w_skip;
  logic             w_last_step;
  logic [WIDTH-1:0] w_step_data;
  logic             w_step_bit;

  assign w_accept    = (r_state == ST_IDLE) && bus.in_valid;
  assign w_skip      = skip_shift(bus.in_op, (bus.in_amt == c_amt_zero), c_ror_en);
  assign w_last_step = (r_count == c_amt_one);

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_op   (r_op),
    .i_data (r_work),
    .o_data (w_step_data),
    .o_bit  (w_step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_state_nxt = w_skip ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last_step) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Working register doubles as the result register; it only moves in IDLE/SHIFT,
  // so the result is stable for as long as DONE is held by backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= OP_LSL;
      r_work  <= '0;
      r_count <= '0;
      r_cout  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= bus.in_op;
        r_work  <= bus.in_data;
        r_count <= w_skip ? c_amt_zero : bus.in_amt;
        r_cout  <= 1'b0;
      end else if (r_state == ST_SHIFT) begin
        r_work  <= w_step_data;
        r_cout  <= w_step_bit;
        r_count <= r_count - c_amt_one;
      end
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_data  = r_work;
  assign bus.out_cout  = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_seq_shift_unit                                               |
// | Brief    : Scoreboard bench for seq_shift_unit with a behavioural model.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seq_shift_unit;
  import shifter_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] data;
    logic         cout;
    int           acc;
    int           lat;
    int           bp;
    string        name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  seq_shift_unit_if #(.WIDTH(W), .AMT_W(4)) bus ();

  seq_shift_unit #(.WIDTH(W), .AMT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: whole shift computed at once from the operation definitions.
  function automatic logic [W:0] model(input logic [1:0] op, input int amt, input logic [W-1:0] d);
    logic [W-1:0] r;
    logic         c;
    r = d;
    c = 1'b0;
    case (op)
      2'd0: begin r = d << amt; if (amt > 0) c = d[W-amt]; end
      2'd1: begin r = d >> amt; if (amt > 0) c = d[amt-1]; end
      2'd2: begin r = $signed(d) >>> amt; if (amt > 0) c = d[amt-1]; end
      default: begin
`ifdef SHIFTER_ROR_EN
        r = (d >> amt) | (d << (W - amt));
        if (amt > 0) c = d[amt-1];
`else
        r = d;
        c = 1'b0;
`endif
      end
    endcase
    return {c, r};
  endfunction

  task automatic issue(input logic [1:0] op, input int amt, input logic [W-1:0] d,
                       input int bp, input string nm);
    int   w;
    exp_t e;
    logic [W:0] m;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) chk({nm, "_in_ready_timeout"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = shift_op_e'(op);
    bus.in_amt   = 4'(amt);
    bus.in_data  = d;
    m      = model(op, amt, d);
    e.data = m[W-1:0];
    e.cout = m[W];
    e.acc  = cyc + 1;
`ifdef SHIFTER_ROR_EN
    e.lat  = amt + 1;
`else
    e.lat  = (op == 2'd3) ? 1 : amt + 1;
`endif
    e.bp   = bp;
    e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_op    = shift_op_e'($urandom_range(0, 3));
    bus.in_amt   = 4'($urandom);
    bus.in_data  = W'($urandom);
  endtask

  // Monitor: pops an expectation whenever a new result appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_data"}, 32'(bus.out_data), 32'(e.data));
          chk({e.name, "_cout"}, 32'(bus.out_cout), 32'(e.cout));
          chk({e.name, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
          if (e.bp > 0) begin
            bus.out_ready = 1'b0;
            for (int i = 0; i < e.bp; i++) begin
              @(negedge clk);
              chk({e.name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
              chk({e.name, "_hold_data"}, 32'(bus.out_data), 32'(e.data));
              chk({e.name, "_hold_cout"}, 32'(bus.out_cout), 32'(e.cout));
              chk({e.name, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            end
            bus.out_ready = 1'b1;
          end else begin
            chk({e.name, "_done_in_ready"}, 32'(bus.in_ready), 32'd0);
          end
          @(negedge clk);
          chk({e.name, "_post_valid"}, 32'(bus.out_valid), 32'd0);
          chk({e.name, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
        end
      end
    end
  end

  initial begin
    int w;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_LSL;
    bus.in_amt    = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_data", 32'(bus.out_data), 32'd0);
    chk("reset_out_cout", 32'(bus.out_cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(2'd0, 4, 16'h00F1, 0, "lsl4");
    issue(2'd2, 15, 16'h8000, 0, "asr15");
    issue(2'd1, 1, 16'h8001, 0, "lsr1");
    issue(2'd1, 15, 16'h8001, 0, "lsr15");
    issue(2'd0, 15, 16'h8001, 0, "lsl15");
    for (int op = 0; op < 4; op++) issue(2'(op), 0, 16'hA5A5, 0, "amt0");
    issue(2'd3, 2, 16'h0003, 0, "ror2");
    issue(2'd3, 15, 16'h1234, 0, "ror15");
    issue(2'd0, 3, 16'h1234, 6, "bp6");

    // Abort a long shift with an asynchronous reset.
    issue(2'd0, 9, 16'hFFFF, 0, "aborted");
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_data", 32'(bus.out_data), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("abort_edge_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'd2, 5, 16'h9C3A, 0, "after_abort");

    for (int n = 0; n < 40; n++) begin
      int bp;
      bp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), W'($urandom), bp, "rand");
    end

    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
